// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and encodings for the multicycle CPU sequencer
//
// Contents:
//   state_e   : sequencer states
//   instr_e   : instruction classes resolved in DECODE
//   REG_*     : reg_sel encodings (Rd/Rm/Rn/none)
//   WBS_*     : wb_sel encodings (C / imm8 / memory data)
//   OPC_*/OP_*: opcode and op field values from IR[15:11]
//   classify(): maps {opcode, op} to an instruction class
// Optional feature macro: CPU_SEQ_BRANCH_EN (opcode 001 decodes as a branch).

package cpu_pkg;

  typedef enum logic [4:0] {
    S_RST,
    S_FETCH,
    S_IR_LD,
    S_DECODE,
    S_WB_IMM,
    S_RD_A,
    S_RD_B,
    S_EXEC,
    S_STAT,
    S_WB_C,
    S_ADDR,
    S_ADDR_LD,
    S_RD_D,
    S_MEM_RD,
    S_WB_M,
    S_MEM_WR,
    S_HALT,
    S_FAULT,
    S_BR_T,
    S_BR_N
  } state_e;

  typedef enum logic [2:0] {
    I_MOVI,
    I_MOVR,
    I_ALU,
    I_LDR,
    I_STR,
    I_HALT,
    I_BR,
    I_ILL
  } instr_e;

  localparam logic [1:0] REG_RD   = 2'b00;
  localparam logic [1:0] REG_RM   = 2'b01;
  localparam logic [1:0] REG_RN   = 2'b10;
  localparam logic [1:0] REG_NONE = 2'b11;

  localparam logic [1:0] WBS_C   = 2'b00;
  localparam logic [1:0] WBS_IMM = 2'b10;
  localparam logic [1:0] WBS_MEM = 2'b11;

  localparam logic [2:0] OPC_BR   = 3'b001;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_ZERO    = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  function automatic instr_e classify(input logic [2:0] opc, input logic [1:0] op);
    instr_e r;
    r = I_ILL;
    if (opc == OPC_MOV && op == OP_MOV_IMM) r = I_MOVI;
    else if (opc == OPC_MOV && op == OP_ZERO) r = I_MOVR;
    else if (opc == OPC_ALU) r = I_ALU;
    else if (opc == OPC_LDR && op == OP_ZERO) r = I_LDR;
    else if (opc == OPC_STR && op == OP_ZERO) r = I_STR;
    else if (opc == OPC_HALT && op == OP_ZERO) r = I_HALT;
`ifdef CPU_SEQ_BRANCH_EN
    else if (opc == OPC_BR) r = I_BR;
`endif
    return r;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - memory request wait counter with timeout pulse
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   active_i   : sequencer is in a memory request state this cycle
//   ack_i      : memory acknowledges the request this cycle
//   timeout_o  : MEM_TIMEOUT consecutive cycles passed without ack (combinational)
// MEM_TIMEOUT = 0 disables the timeout entirely.

module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  input  logic ack_i,
  output logic timeout_o
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit EN = (MEM_TIMEOUT > 0);
  // Count value held during the last permitted wait cycle; no ack there means timeout.
  localparam logic [CW-1:0] LAST = EN ? CW'(MEM_TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  // Any request ends either with ack or with a timeout (which leaves the
  // request states), so clearing on !active or ack restarts every request at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || ack_i || !EN) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack in the final permitted cycle takes priority over the timeout.
  assign timeout_o = EN && active_i && !ack_i && (cnt_q == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multicycle Moore control sequencer for the RISC datapath
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   opcode, op          : IR[15:13], IR[12:11]
//   mem_ack             : memory completes the current request
//   cond_met            : branch condition (only with CPU_SEQ_BRANCH_EN)
//   reg_sel, wb_sel     : register file select and write-back source
//   w_en, en_A/B/C, en_status, sel_A, sel_B : datapath enables and ALU muxes
//   load_pc, clear_pc, pc_sel               : PC control
//   load_ir, load_addr, sel_addr            : IR / address register control
//   mem_req, mem_we     : memory request and write strobe
//   halted, fault       : sticky status
// Optional feature macro: CPU_SEQ_BRANCH_EN.

module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic       mem_ack,
  input  logic       cond_met,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic       load_pc,
  output logic       clear_pc,
  output logic       pc_sel,
  output logic       load_ir,
  output logic       load_addr,
  output logic       sel_addr,
  output logic       mem_req,
  output logic       mem_we,
  output logic       halted,
  output logic       fault
);

  state_e     state_q;
  instr_e     ins_q;   // instruction class captured in DECODE
  logic [1:0] op_q;    // op field captured in DECODE (CMP / MVN distinctions)
  logic       mem_active;
  logic       timeout;

  assign mem_active = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .active_i (mem_active),
    .ack_i    (mem_ack),
    .timeout_o(timeout)
  );

`ifndef CPU_SEQ_BRANCH_EN
  logic unused_cond;
  assign unused_cond = cond_met;
`endif

  // The instruction class is latched in DECODE so later states depend only on
  // registered values; the branch condition is folded into the choice of BR state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      ins_q   <= I_ILL;
      op_q    <= OP_ZERO;
    end else begin
      case (state_q)
        S_RST:     state_q <= S_FETCH;
        S_FETCH: begin
          if (mem_ack)      state_q <= S_IR_LD;
          else if (timeout) state_q <= S_FAULT;
        end
        S_IR_LD:   state_q <= S_DECODE;
        S_DECODE: begin
          ins_q <= classify(opcode, op);
          op_q  <= op;
          case (classify(opcode, op))
            I_MOVI:               state_q <= S_WB_IMM;
            I_MOVR:               state_q <= S_RD_B;
            I_ALU, I_LDR, I_STR:  state_q <= S_RD_A;
            I_HALT:               state_q <= S_HALT;
            I_BR:                 state_q <= cond_met ? S_BR_T : S_BR_N;
            default:              state_q <= S_FAULT;
          endcase
        end
        S_WB_IMM:  state_q <= S_FETCH;
        S_RD_A:    state_q <= (ins_q == I_ALU) ? S_RD_B : S_ADDR;
        S_RD_B:    state_q <= (ins_q == I_ALU && op_q == OP_CMP) ? S_STAT : S_EXEC;
        S_EXEC:    state_q <= (ins_q == I_STR) ? S_MEM_WR : S_WB_C;
        S_STAT:    state_q <= S_FETCH;
        S_WB_C:    state_q <= S_FETCH;
        S_ADDR:    state_q <= S_ADDR_LD;
        S_ADDR_LD: state_q <= (ins_q == I_LDR) ? S_MEM_RD : S_RD_D;
        S_RD_D:    state_q <= S_EXEC;
        S_MEM_RD: begin
          if (mem_ack)      state_q <= S_WB_M;
          else if (timeout) state_q <= S_FAULT;
        end
        S_WB_M:    state_q <= S_FETCH;
        S_MEM_WR: begin
          if (mem_ack)      state_q <= S_FETCH;
          else if (timeout) state_q <= S_FAULT;
        end
        S_HALT:    state_q <= S_HALT;
        S_FAULT:   state_q <= S_FAULT;
        S_BR_T:    state_q <= S_FETCH;
        S_BR_N:    state_q <= S_FETCH;
        default:   state_q <= S_FAULT;
      endcase
    end
  end

  always_comb begin
    reg_sel   = REG_NONE;
    wb_sel    = WBS_C;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    load_pc   = 1'b0;
    clear_pc  = 1'b0;
    pc_sel    = 1'b0;
    load_ir   = 1'b0;
    load_addr = 1'b0;
    sel_addr  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    case (state_q)
      S_RST: begin
        clear_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_FETCH: begin
        sel_addr = 1'b1;
        mem_req  = 1'b1;
      end
      S_IR_LD: begin
        load_ir = 1'b1;
        load_pc = 1'b1;
      end
      S_WB_IMM: begin
        reg_sel = REG_RN;
        wb_sel  = WBS_IMM;
        w_en    = 1'b1;
      end
      S_RD_A: begin
        reg_sel = REG_RN;
        en_A    = 1'b1;
      end
      S_RD_B: begin
        reg_sel = REG_RM;
        en_B    = 1'b1;
      end
      S_EXEC: begin
        en_C  = 1'b1;
        // Zero on the A side turns the ALU into a pass/negate of B.
        sel_A = (ins_q == I_MOVR) || (ins_q == I_STR) ||
                (ins_q == I_ALU && op_q == OP_MVN);
      end
      S_STAT:    en_status = 1'b1;
      S_WB_C: begin
        reg_sel = REG_RD;
        wb_sel  = WBS_C;
        w_en    = 1'b1;
      end
      S_ADDR: begin
        en_C  = 1'b1;
        sel_B = 1'b1;
      end
      S_ADDR_LD: load_addr = 1'b1;
      S_RD_D: begin
        reg_sel = REG_RD;
        en_B    = 1'b1;
      end
      S_MEM_RD:  mem_req = 1'b1;
      S_WB_M: begin
        reg_sel = REG_RD;
        wb_sel  = WBS_MEM;
        w_en    = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_HALT:    halted = 1'b1;
      S_FAULT:   fault  = 1'b1;
`ifdef CPU_SEQ_BRANCH_EN
      S_BR_T: begin
        load_pc = 1'b1;
        pc_sel  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized self-checking bench for cpu_sequencer

module tb_cpu_sequencer;

  localparam int T = 4;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [2:0] opcode   = 3'b000;
  logic [1:0] op       = 2'b00;
  logic       mem_ack  = 1'b0;
  logic       cond_met = 1'b0;
  logic [1:0] reg_sel, wb_sel;
  logic w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
  logic load_pc, clear_pc, pc_sel, load_ir, load_addr, sel_addr;
  logic mem_req, mem_we, halted, fault;

  typedef struct packed {
    logic [1:0] reg_sel;
    logic [1:0] wb_sel;
    logic w_en, en_a, en_b, en_c, en_status, sel_a, sel_b;
    logic load_pc, clear_pc, pc_sel, load_ir, load_addr, sel_addr;
    logic mem_req, mem_we, halted, fault;
  } outs_t;

  outs_t act;
  int n_chk = 0;
  int n_fail = 0;
  int mreq_cnt = 0;

  cpu_sequencer #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .op(op), .mem_ack(mem_ack),
    .cond_met(cond_met), .reg_sel(reg_sel), .wb_sel(wb_sel), .w_en(w_en),
    .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_status(en_status),
    .sel_A(sel_A), .sel_B(sel_B), .load_pc(load_pc), .clear_pc(clear_pc),
    .pc_sel(pc_sel), .load_ir(load_ir), .load_addr(load_addr),
    .sel_addr(sel_addr), .mem_req(mem_req), .mem_we(mem_we),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  assign act = {reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
                load_pc, clear_pc, pc_sel, load_ir, load_addr, sel_addr,
                mem_req, mem_we, halted, fault};

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, a, e, $time);
    end
  endtask

  // Expected outputs for one named step of an instruction.
  function automatic outs_t step_out(input string s, input bit x);
    outs_t r;
    r = '0;
    r.reg_sel = 2'b11;
    case (s)
      "RST":    begin r.clear_pc = 1; r.load_pc = 1; end
      "FETCH":  begin r.sel_addr = 1; r.mem_req = 1; end
      "IRLD":   begin r.load_ir = 1; r.load_pc = 1; end
      "WBIMM":  begin r.reg_sel = 2'b10; r.wb_sel = 2'b10; r.w_en = 1; end
      "RDA":    begin r.reg_sel = 2'b10; r.en_a = 1; end
      "RDB":    begin r.reg_sel = 2'b01; r.en_b = 1; end
      "EXEC":   begin r.en_c = 1; r.sel_a = x; end
      "STAT":   r.en_status = 1;
      "WBC":    begin r.reg_sel = 2'b00; r.wb_sel = 2'b00; r.w_en = 1; end
      "ADDR":   begin r.en_c = 1; r.sel_b = 1; end
      "ADDRLD": r.load_addr = 1;
      "RDD":    begin r.reg_sel = 2'b00; r.en_b = 1; end
      "MEMRD":  r.mem_req = 1;
      "WBM":    begin r.reg_sel = 2'b00; r.wb_sel = 2'b11; r.w_en = 1; end
      "MEMWR":  begin r.mem_req = 1; r.mem_we = 1; end
      "HALT":   r.halted = 1;
      "FAULT":  r.fault = 1;
      "BR":     begin r.load_pc = x; r.pc_sel = x; end
      default:  ;
    endcase
    return r;
  endfunction

  // One clock cycle: entered and left at posedge+1, outputs compared at negedge.
  task automatic cyc(input string s, input bit x, input logic ack);
    outs_t e;
    e = step_out(s, x);
    mem_ack = ack;
    @(negedge clk);
    if (act.mem_req) mreq_cnt++;
    check({"out_", s}, 32'(act), 32'(e));
    @(posedge clk);
    #1;
  endtask

  // Non-request step: mem_ack is random there and must be ignored.
  task automatic plain(input string s, input bit x);
    cyc(s, x, 1'($urandom_range(0, 1)));
  endtask

  // Request held for w wait cycles before ack; w >= T means timeout after T cycles.
  task automatic mem_phase(input string s, input int w, inout int lat, output bit to);
    int n;
    to = (T > 0) && (w >= T);
    n = to ? T : w + 1;
    for (int i = 0; i < n; i++) begin
      cyc(s, 1'b0, (!to && i == n - 1));
      lat++;
    end
  endtask

  task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input int w0,
                           input int w1, input bit cm, output int lat, output string term);
    bit to;
    opcode = opc; op = o; cond_met = cm; lat = 0; term = "";
    mem_phase("FETCH", w0, lat, to);
    if (to) begin term = "FAULT"; return; end
    plain("IRLD", 0); plain("DEC", 0); lat += 2;
    if ({opc, o} == 5'b110_10) begin
      plain("WBIMM", 0); lat++;
    end else if ({opc, o} == 5'b110_00) begin
      plain("RDB", 0); plain("EXEC", 1); plain("WBC", 0); lat += 3;
    end else if (opc == 3'b101) begin
      plain("RDA", 0); plain("RDB", 0); lat += 2;
      if (o == 2'b01) begin
        plain("STAT", 0); lat++;
      end else begin
        plain("EXEC", o == 2'b11); plain("WBC", 0); lat += 2;
      end
    end else if ({opc, o} == 5'b011_00) begin
      plain("RDA", 0); plain("ADDR", 0); plain("ADDRLD", 0); lat += 3;
      mem_phase("MEMRD", w1, lat, to);
      if (to) term = "FAULT";
      else begin plain("WBM", 0); lat++; end
    end else if ({opc, o} == 5'b100_00) begin
      plain("RDA", 0); plain("ADDR", 0); plain("ADDRLD", 0); plain("RDD", 0);
      plain("EXEC", 1); lat += 5;
      mem_phase("MEMWR", w1, lat, to);
      if (to) term = "FAULT";
    end else if ({opc, o} == 5'b111_00) begin
      term = "HALT";
`ifdef CPU_SEQ_BRANCH_EN
    end else if (opc == 3'b001) begin
      plain("BR", cm); lat++;
`endif
    end else begin
      term = "FAULT";
    end
  endtask

  task automatic absorb(input string s, input int n);
    for (int i = 0; i < n; i++) plain(s, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    plain("RST", 0);
    rst_n = 1'b1;
    plain("RST", 0);
  endtask

  initial begin
    int lat;
    string term;
    logic [2:0] ropc;
    logic [1:0] rop;
    int w0, w1;

    @(posedge clk);
    #1;
    do_reset();

    // MOV imm, zero wait: w_en in cycle 4 counted from the RST cycle.
    run_instr(3'b110, 2'b10, 0, 0, 0, lat, term);
    check("lat_movi", 32'(lat), 32'd4);
    check("movi_back_in_fetch", {30'd0, mem_req, sel_addr}, 32'd3);

    run_instr(3'b101, 2'b01, 0, 0, 0, lat, term);
    check("lat_cmp", 32'(lat), 32'd6);
    run_instr(3'b110, 2'b00, 0, 0, 0, lat, term);
    check("lat_movr", 32'(lat), 32'd6);
    run_instr(3'b101, 2'b00, 0, 0, 0, lat, term);
    check("lat_add", 32'(lat), 32'd7);
    run_instr(3'b011, 2'b00, 0, 0, 0, lat, term);
    check("lat_ldr", 32'(lat), 32'd8);
    run_instr(3'b100, 2'b00, 0, 0, 0, lat, term);
    check("lat_str", 32'(lat), 32'd9);

    // ADD with ack held off 3 cycles.
    mreq_cnt = 0;
    run_instr(3'b101, 2'b00, 3, 0, 0, lat, term);
    check("add_wait_mreq", 32'(mreq_cnt), 32'd4);
    check("add_wait_lat", 32'(lat), 32'd10);

    // Reset mid-request, then a maximum permitted wait must not fault.
    opcode = 3'b110; op = 2'b10;
    cyc("FETCH", 0, 1'b0);
    cyc("FETCH", 0, 1'b0);
    do_reset();
    run_instr(3'b110, 2'b10, T - 1, 0, 0, lat, term);
    check("maxwait_no_fault", 32'(term == ""), 32'd1);

    // Timeout on fetch: fault after T request cycles, sticky until a reset pulse.
    mreq_cnt = 0;
    run_instr(3'b110, 2'b10, 1000, 0, 0, lat, term);
    check("timeout_mreq", 32'(mreq_cnt), 32'(T));
    absorb("FAULT", 6);
    check("fault_sticky", 32'(fault), 32'd1);
    do_reset();

    // Timeout during a store data phase.
    run_instr(3'b100, 2'b00, 0, 1000, 0, lat, term);
    check("str_timeout_term", 32'(term == "FAULT"), 32'd1);
    absorb("FAULT", 2);
    do_reset();

    // HALT is absorbing.
    run_instr(3'b111, 2'b00, 0, 0, 0, lat, term);
    absorb("HALT", 100);
    check("halt_sticky", 32'(halted), 32'd1);
    do_reset();

    // Opcode 001 with both condition values.
    for (int c = 0; c < 2; c++) begin
      run_instr(3'b001, 2'b00, 0, 0, 1'(c), lat, term);
`ifdef CPU_SEQ_BRANCH_EN
      check("lat_br", 32'(lat), 32'd4);
`else
      check("br_faults", 32'(term == "FAULT"), 32'd1);
      absorb("FAULT", 2);
      do_reset();
`endif
    end

    // Randomized instruction stream.
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0: begin ropc = 3'b110; rop = 2'b10; end
        1: begin ropc = 3'b110; rop = 2'b00; end
        2, 3: begin ropc = 3'b101; rop = 2'($urandom_range(0, 3)); end
        4, 6: begin ropc = 3'b011; rop = 2'b00; end
        5, 9: begin ropc = 3'b100; rop = 2'b00; end
        7: begin ropc = 3'b001; rop = 2'($urandom_range(0, 3)); end
        default: begin ropc = 3'($urandom_range(0, 7)); rop = 2'($urandom_range(0, 3)); end
      endcase
      w0 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T - 1, T + 2)) : int'($urandom_range(0, 2));
      w1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T - 1, T + 2)) : int'($urandom_range(0, 2));
      run_instr(ropc, rop, w0, w1, 1'($urandom_range(0, 1)), lat, term);
      if (term != "") begin
        absorb(term, int'($urandom_range(1, 4)));
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
